servo_turret_sequencer: RTL
===========================

Name: servo_turret_sequencer

Overview:
- Parametrised successor to the single-turret servo driver.
- Generates two frame-synchronous PWM servo outputs: aim (positional) and fire (release spool).
- Sequences them from N_DIR direction phototransistor inputs: detect, slew-limited aim, settle, fire one band, hold, re-arm.
- Sits between the sensor front-end and the servos; `aiming` halts the rover drive logic while the turret engages.

Parameters:
- N_DIR, 3, number of direction sensors; index 0 has highest priority.
- PW, 18, width of pulse offset registers.
- PERIOD_CYCLES, 2000000, PWM frame length in clocks (20 ms at 100 MHz).
- MIN_PULSE, 100000, base high time in clocks.
- AIM_TABLE, {18'd8000,18'd9000,18'd3300}, N_DIR*PW packed aim offsets; entry i is at bits [i*PW +: PW].
- AIM_HOME, 9000, aim offset after reset.
- SLEW_STEP, 500, maximum aim offset change per frame.
- SETTLE_FRAMES, 10, frames to wait after aim reaches target.
- FIRE_FRAMES, 83, frames the fire servo is given to reach its new offset.
- RELEASE_STEP, 30000, fire offset increment per shot.
- MAX_SHOTS, 8, magazine size. Legal only if MAX_SHOTS*RELEASE_STEP <= 2^PW-1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sensors  in  2*N_DIR  per-direction code [2i+1:2i]: 2'b10 = new enemy, any nonzero = target present, 2'b00 = clear.
- aim_servo  out  1  aim PWM.
- fire_servo  out  1  fire PWM.
- aiming  out  1  high from detection until the shot completes; rover stops while high.
- shots_fired  out  $clog2(MAX_SHOTS+1)  shots completed.
- magazine_empty  out  1  high once shots_fired == MAX_SHOTS.

Behaviour:
- Reset (async, active-high) clears:
  - frame counter = 0, state = IDLE
  - aim_off = aim_act = AIM_HOME
  - fire_off = fire_act = 0, release_next = 0
  - all outputs 0
- Frame counter runs 0..PERIOD_CYCLES-1, then wraps. `tick` is high in the cycle where counter == PERIOD_CYCLES-1.
- Shadow registers: on `tick`, aim_act <= aim_off and fire_act <= fire_off. The PWM compare uses only the *_act registers, so there are no mid-frame width changes.
- PWM outputs are registered:
  - aim_servo <= (counter < MIN_PULSE + aim_act); fire_servo uses fire_act the same way.
  - Compare is done at PW+1 bits minimum (no truncation).
  - Output rises the cycle after counter = 0 and holds for exactly MIN_PULSE + *_act cycles.
- Detection: sel = lowest index i with sensors[2i+1:2i] == 2'b10. `present` = any sensor pair nonzero.
- FSM states: IDLE, SLEW, SETTLE, FIRE, HOLD, EMPTY.
  - IDLE: if sel is valid, target <= AIM_TABLE[sel], aiming <= 1, go to SLEW. Sampled every cycle; detection is not deferred to a frame boundary.
  - SLEW: on each tick, aim_off moves toward target by min(SLEW_STEP, |target - aim_off|), using unsigned compare and no overshoot. When aim_off == target, go to SETTLE with settle_cnt = 0. If the target already equals aim_off on entry, SLEW lasts exactly 1 cycle.
  - SETTLE: settle_cnt increments on tick. At SETTLE_FRAMES, go to FIRE with fire_off <= release_next + RELEASE_STEP and frame_cnt = 0.
  - FIRE: frame_cnt increments on tick. At FIRE_FRAMES:
    - release_next <= fire_off and shots_fired++.
    - aiming <= 0.
    - Go to EMPTY if the new count == MAX_SHOTS, else go to HOLD.
  - HOLD: 2'b10 codes are ignored (same target). Go to IDLE when `present` == 0 for one cycle.
  - EMPTY: terminal until reset. magazine_empty = 1, aiming = 0, sensors ignored. Aim and fire offsets hold their last values.
- New-enemy codes arriving during SLEW, SETTLE or FIRE are ignored; there is no retargeting mid-engagement.
- Fire offset only increases. release_next never wraps, guaranteed by the parameter legality rule.
- Reset asserted mid-FIRE aborts the shot: shots_fired returns to 0 and the outputs go low asynchronously.

Test Plan:
All scenarios use PERIOD_CYCLES=100, MIN_PULSE=10, AIM_HOME=20, AIM_TABLE={60,40,0}, SLEW_STEP=15, SETTLE_FRAMES=2, FIRE_FRAMES=3, RELEASE_STEP=5, MAX_SHOTS=2.
1. Reset, idle 3 frames -> aim_servo high 30 cycles per frame; fire_servo high 10; aiming=0; shots_fired=0.
2. sensors[1:0]=2'b10 (target 0) -> aiming=1 next cycle. Aim widths over successive frames are 30, then 15, then 10 (offsets 20, 5, 0). Fire width becomes 15 after settle+fire. shots_fired=1, aiming=0, state HOLD.
3. Assert sensors[1:0]=2'b10 and sensors[5:4]=2'b10 together -> index 0 wins (target 0, not 60).
4. In HOLD with sensors[3:2]=2'b10 -> no new engagement. Drop all sensors to 00, then sensors[3:2]=2'b10 -> engages target 40. Fire width ends at 20, shots_fired=2, magazine_empty=1, state EMPTY; further 2'b10 is ignored.
5. Pulse reset mid-FIRE -> all outputs 0 immediately; after release, aim width 30, fire width 10, shots_fired=0.
6. Retarget input (sensors[5:4]=2'b10) during SLEW -> ignored; aim continues to the original target.

Source files
------------

// File: rtl/servo_turret_sequencer.sv
// Two-channel frame-synchronous servo PWM with a detect/slew/settle/fire/hold sequencer
// driven by prioritised direction sensors.
module servo_turret_sequencer #(
   parameter int                  N_DIR         = 3,
   parameter int                  PW            = 18,
   parameter int                  PERIOD_CYCLES = 2000000,
   parameter int                  MIN_PULSE     = 100000,
   parameter logic [N_DIR*PW-1:0] AIM_TABLE     = {18'd8000, 18'd9000, 18'd3300},
   parameter int                  AIM_HOME      = 9000,
   parameter int                  SLEW_STEP     = 500,
   parameter int                  SETTLE_FRAMES = 10,
   parameter int                  FIRE_FRAMES   = 83,
   parameter int                  RELEASE_STEP  = 30000,
   parameter int                  MAX_SHOTS     = 8
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [2*N_DIR-1:0]             sensors,
   output logic                           aim_servo,
   output logic                           fire_servo,
   output logic                           aiming,
   output logic [$clog2(MAX_SHOTS+1)-1:0] shots_fired,
   output logic                           magazine_empty
);

   localparam int CNT_W = $clog2(PERIOD_CYCLES);
   localparam int CMP_W = ((CNT_W > PW) ? CNT_W : PW) + 2;
   localparam int SC_W  = $clog2(SETTLE_FRAMES + 1);
   localparam int FC_W  = $clog2(FIRE_FRAMES + 1);
   localparam int SH_W  = $clog2(MAX_SHOTS + 1);

   typedef enum logic [2:0] {IDLE, SLEW, SETTLE, FIRE, HOLD, EMPTY} state_t;

   state_t          state;
   logic [CNT_W-1:0] counter;
   logic            tick;
   logic [PW-1:0]   aim_off, aim_act, fire_off, fire_act, release_next, target;
   logic [PW-1:0]   aim_next, sel_target;
   logic            sel_valid, present;
   logic [SC_W-1:0] settle_cnt;
   logic [FC_W-1:0] frame_cnt;

   assign tick    = (counter == CNT_W'(PERIOD_CYCLES - 1));
   assign present = |sensors;

   // Frame counter and shadow registers: PWM widths only change at a frame boundary.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         counter  <= '0;
         aim_act  <= PW'(AIM_HOME);
         fire_act <= '0;
      end else begin
         counter <= tick ? '0 : counter + CNT_W'(1);
         if (tick) begin
            aim_act  <= aim_off;
            fire_act <= fire_off;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         aim_servo  <= 1'b0;
         fire_servo <= 1'b0;
      end else begin
         aim_servo  <= CMP_W'(counter) < (CMP_W'(MIN_PULSE) + CMP_W'(aim_act));
         fire_servo <= CMP_W'(counter) < (CMP_W'(MIN_PULSE) + CMP_W'(fire_act));
      end
   end

   // Lowest index with a new-enemy code wins; scanning downward lets it overwrite higher ones.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sel_valid  = 1'b0;
      sel_target = '0;
      for (int i = N_DIR - 1; i >= 0; i--) begin
         if (sensors[2*i +: 2] == 2'b10) begin
            sel_valid  = 1'b1;
            sel_target = AIM_TABLE[i*PW +: PW];
         end
      end
   end

   always_comb begin
      aim_next = target;
      if (target > aim_off) begin
         if ((target - aim_off) > PW'(SLEW_STEP)) aim_next = aim_off + PW'(SLEW_STEP);
      end else if ((aim_off - target) > PW'(SLEW_STEP)) begin
         aim_next = aim_off - PW'(SLEW_STEP);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         target         <= PW'(AIM_HOME);
         aim_off        <= PW'(AIM_HOME);
         fire_off       <= '0;
         release_next   <= '0;
         settle_cnt     <= '0;
         frame_cnt      <= '0;
         aiming         <= 1'b0;
         shots_fired    <= '0;
         magazine_empty <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  target <= sel_target;
                  aiming <= 1'b1;
                  state  <= SLEW;
               end
            end
            SLEW: begin
               if (aim_off == target) begin
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end else if (tick) begin
                  aim_off <= aim_next;
               end
            end
            SETTLE: begin
               if (tick) begin
                  settle_cnt <= settle_cnt + SC_W'(1);
                  if (settle_cnt == SC_W'(SETTLE_FRAMES - 1)) begin
                     fire_off  <= release_next + PW'(RELEASE_STEP);
                     frame_cnt <= '0;
                     state     <= FIRE;
                  end
               end
            end
            FIRE: begin
               if (tick) begin
                  frame_cnt <= frame_cnt + FC_W'(1);
                  if (frame_cnt == FC_W'(FIRE_FRAMES - 1)) begin
                     release_next <= fire_off;
                     shots_fired  <= shots_fired + SH_W'(1);
                     aiming       <= 1'b0;
                     if (shots_fired == SH_W'(MAX_SHOTS - 1)) begin
                        magazine_empty <= 1'b1;
                        state          <= EMPTY;
                     end else begin
                        state <= HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               if (!present) state <= IDLE;
            end
            EMPTY: begin
               aiming <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
